// File: rtl/button_mode_selector.sv
// Three-button mode selector: each raw button is synchronized and debounced,
// a debounced press yields a one-cycle pulse, and the pulses drive a latched
// one-hot mode register with toggle-off and simultaneous-press detection.
module button_mode_selector #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn_raw,
  output logic [2:0] btn_pulse,
  output logic [2:0] mode,
  output logic       mode_valid,
  output logic       conflict
);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    W_HIGH = 2'd1,
    S_HIGH = 2'd2,
    W_LOW  = 2'd3
  } db_state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  db_state_e        r_state [3];
  logic [CNT_W-1:0] r_cnt   [3];
  logic [2:0]       r_rise;
  logic [2:0]       r_btn_pulse;
  logic [2:0]       r_mode;
  logic             r_mode_valid;
  logic             r_conflict;

  logic [2:0]       w_s;
  logic [2:0]       w_pulse_m1;
  logic             w_multi;
  logic             w_single;

  assign w_s = r_sync2;

  // Two or more pulse bits set: p & (p - 1) clears the lowest set bit.
  assign w_pulse_m1 = r_btn_pulse - 3'd1;
  assign w_multi    = |(r_btn_pulse & w_pulse_m1);
  assign w_single   = (r_btn_pulse != 3'b000) && !w_multi;

  // Two-flop synchronizer per button; btn_raw is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce FSM; r_rise flags the edge that accepts a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        r_state[k] <= S_LOW;
        r_cnt[k]   <= '0;
      end
      r_rise <= 3'b000;
    end else begin
      for (int k = 0; k < 3; k++) begin
        r_rise[k] <= 1'b0;
        case (r_state[k])
          S_LOW: begin
            r_cnt[k] <= '0;
            if (w_s[k]) r_state[k] <= W_HIGH;
          end
          W_HIGH: begin
            if (!w_s[k]) begin
              r_state[k] <= S_LOW;
              r_cnt[k]   <= '0;
            end else if (r_cnt[k] == CntLast) begin
              r_state[k] <= S_HIGH;
              r_cnt[k]   <= '0;
              r_rise[k]  <= 1'b1;
            end else begin
              r_cnt[k] <= r_cnt[k] + 1'b1;
            end
          end
          S_HIGH: begin
            r_cnt[k] <= '0;
            if (!w_s[k]) r_state[k] <= W_LOW;
          end
          W_LOW: begin
            if (w_s[k]) begin
              r_state[k] <= S_HIGH;
              r_cnt[k]   <= '0;
            end else if (r_cnt[k] == CntLast) begin
              // Release accepted silently; no pulse on entry to S_LOW.
              r_state[k] <= S_LOW;
              r_cnt[k]   <= '0;
            end else begin
              r_cnt[k] <= r_cnt[k] + 1'b1;
            end
          end
          default: begin
            r_state[k] <= S_LOW;
            r_cnt[k]   <= '0;
          end
        endcase
      end
    end
  end

  // Registered one-cycle press pulse, one edge after the press is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_pulse <= 3'b000;
    end else begin
      r_btn_pulse <= r_rise;
    end
  end

  // Mode register: single press selects or toggles off; multi-press holds mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode       <= 3'b000;
      r_mode_valid <= 1'b0;
      r_conflict   <= 1'b0;
    end else begin
      r_conflict <= 1'b0;
      if (w_multi) begin
        r_conflict <= 1'b1;
      end else if (w_single) begin
        if (r_mode == r_btn_pulse) begin
          r_mode       <= 3'b000;
          r_mode_valid <= 1'b0;
        end else begin
          r_mode       <= r_btn_pulse;
          r_mode_valid <= 1'b1;
        end
      end
    end
  end

  assign btn_pulse  = r_btn_pulse;
  assign mode       = r_mode;
  assign mode_valid = r_mode_valid;
  assign conflict   = r_conflict;

endmodule

// File: tb/tb_button_mode_selector.sv
// Directed bench for button_mode_selector with a short debounce window.
module tb_button_mode_selector;

  localparam int unsigned DbCycles = 4;
  localparam int unsigned CntW     = 3;

  logic       clk;
  logic       reset;
  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;
  logic [2:0] mode;
  logic       mode_valid;
  logic       conflict;

  int n_vec;
  int n_err;
  int npulse;
  int nconf;

  button_mode_selector #(
    .DB_CYCLES(DbCycles),
    .CNT_W    (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_pulse (btn_pulse),
    .mode      (mode),
    .mode_valid(mode_valid),
    .conflict  (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (btn_pulse != 3'b000) npulse++;
    if (conflict) nconf++;
  endtask

  // Raw value first sampled at edge t; pulse expected after t+7, mode after t+8.
  task automatic press_seq(input string tag, input logic [2:0] raw, input logic [2:0] exp_p,
                           input logic [2:0] prev_m, input logic [2:0] new_m,
                           input logic exp_c);
    btn_raw = raw;
    npulse  = 0;
    repeat (7) tick();
    chk({tag, "_early_pulse"}, npulse, 0);
    tick();
    chk({tag, "_pulse"}, {29'd0, btn_pulse}, {29'd0, exp_p});
    chk({tag, "_mode_hold"}, {29'd0, mode}, {29'd0, prev_m});
    tick();
    chk({tag, "_pulse_end"}, {29'd0, btn_pulse}, 0);
    chk({tag, "_mode"}, {29'd0, mode}, {29'd0, new_m});
    chk({tag, "_valid"}, {31'd0, mode_valid}, {31'd0, |new_m});
    chk({tag, "_conflict"}, {31'd0, conflict}, {31'd0, exp_c});
    tick();
    chk({tag, "_conflict_end"}, {31'd0, conflict}, 0);
    chk({tag, "_one_pulse"}, npulse, 1);
  endtask

  task automatic release_all(input string tag, input logic [2:0] exp_m);
    btn_raw = 3'b000;
    npulse  = 0;
    repeat (12) tick();
    chk({tag, "_no_pulse"}, npulse, 0);
    chk({tag, "_mode"}, {29'd0, mode}, {29'd0, exp_m});
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    npulse  = 0;
    nconf   = 0;
    reset   = 1'b0;
    btn_raw = 3'b000;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_pulse", {29'd0, btn_pulse}, 0);
    chk("rst_mode", {29'd0, mode}, 0);
    chk("rst_valid", {31'd0, mode_valid}, 0);
    chk("rst_conflict", {31'd0, conflict}, 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Clean press on bit0, then long hold with no further pulses.
    press_seq("clean", 3'b001, 3'b001, 3'b000, 3'b001, 1'b0);
    npulse = 0;
    repeat (20) tick();
    chk("clean_hold_pulse", npulse, 0);
    chk("clean_hold_mode", {29'd0, mode}, 3'b001);
    chk("clean_hold_valid", {31'd0, mode_valid}, 1);
    release_all("clean_rel", 3'b001);

    // Bit1 bounces every 2 cycles for 20 cycles, then settles high.
    npulse = 0;
    for (int i = 0; i < 5; i++) begin
      btn_raw = 3'b010;
      repeat (2) tick();
      btn_raw = 3'b000;
      repeat (2) tick();
    end
    chk("bounce_no_pulse", npulse, 0);
    chk("bounce_mode", {29'd0, mode}, 3'b001);
    press_seq("bounce", 3'b010, 3'b010, 3'b001, 3'b010, 1'b0);
    release_all("bounce_rel", 3'b010);

    // Toggle bit1 off, then select bit2.
    press_seq("toggle", 3'b010, 3'b010, 3'b010, 3'b000, 1'b0);
    release_all("toggle_rel", 3'b000);
    press_seq("switch", 3'b100, 3'b100, 3'b000, 3'b100, 1'b0);
    release_all("switch_rel", 3'b100);

    // Simultaneous press: conflict pulse, mode held.
    nconf = 0;
    press_seq("simul", 3'b011, 3'b011, 3'b100, 3'b100, 1'b1);
    chk("simul_conf_count", nconf, 1);
    release_all("simul_rel", 3'b100);

    // Reset at cnt=2 during a bit0 press; button stays held across reset.
    btn_raw = 3'b001;
    npulse  = 0;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_pulse", {29'd0, btn_pulse}, 0);
    chk("midrst_mode", {29'd0, mode}, 0);
    chk("midrst_valid", {31'd0, mode_valid}, 0);
    chk("midrst_conflict", {31'd0, conflict}, 0);
    tick();
    tick();
    chk("midrst_no_pulse", npulse, 0);
    reset = 1'b0;
    press_seq("postrst", 3'b001, 3'b001, 3'b000, 3'b001, 1'b0);

    // 200-cycle hold yields no extra pulse.
    npulse = 0;
    repeat (200) tick();
    chk("long_hold_pulse", npulse, 0);
    chk("long_hold_mode", {29'd0, mode}, 3'b001);
    release_all("long_rel", 3'b001);

    // 3-cycle glitch on bit2 is rejected.
    npulse  = 0;
    btn_raw = 3'b100;
    repeat (3) tick();
    btn_raw = 3'b000;
    repeat (15) tick();
    chk("glitch_no_pulse", npulse, 0);
    chk("glitch_mode", {29'd0, mode}, 3'b001);
    chk("glitch_valid", {31'd0, mode_valid}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
